pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Multi-channel pulse-to-level generator; the counterpart of the edge-detect macro.
- Each single-cycle input pulse, such as an edge-detect output, becomes a high level lasting a programmable number of clock cycles.
- Each stretch ends with a one-cycle done pulse.
- Used in the common macro library to drive LEDs, enables, timeouts and strobes into slower logic.

Parameters:
- WIDTH, 8: number of independent channels.
- CNTW, 8: width of the length input and the per-channel counter.
- RETRIG, 1: 1 = a pulse during an active stretch reloads the counter (extends the level); 0 = such a pulse is ignored and flagged on o_miss.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- signal  input  WIDTH  per-channel trigger; a channel triggers in every cycle its bit is 1.
- len  input  CNTW  stretch length in cycles; shared by all channels; sampled in the trigger cycle only.
- o_level  output  WIDTH  stretched level per channel.
- o_done  output  WIDTH  one-cycle pulse in the first cycle after a channel's level falls.
- o_miss  output  WIDTH  one-cycle pulse when a trigger is dropped (RETRIG=0, channel active).
- o_busy  output  1  OR of all o_level bits.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all counters 0, o_level 0, o_done 0, o_miss 0, o_busy 0.
  - Takes effect immediately, including mid-stretch; no o_done is generated for an aborted stretch.
  - Release is synchronous to clk.
- Per channel i: one register cnt[i], CNTW bits. Channel is active when cnt[i] != 0. o_level[i] = (cnt[i] != 0), decoded from register state only, with no input paths.
- Trigger accept:
  - Condition: signal[i]=1 at edge T, len != 0, and (channel idle or RETRIG=1).
  - Action: cnt[i] <= len.
  - Result: o_level[i] is high in cycles T+1 .. T+len, exactly len cycles.
- Decrement: when active and no accepted trigger, cnt[i] <= cnt[i] - 1 each cycle. No wrap: the counter never decrements from 0.
- Done: o_done[i] is registered and equals 1 in the cycle after cnt[i] goes 1 -> 0 (cycle T+len+1), aligned with the falling o_level. It is not asserted if a retrigger reloaded the counter in its final active cycle.
- len = 0: the trigger is ignored. No level, no done, no miss.
- RETRIG=1, trigger while active (including the last active cycle): reload to len. The level stays high continuously through T'+len, where T' is the retrigger edge. No done until the final expiry. A smaller len may shorten the remaining stretch; this is intended.
- RETRIG=0, trigger while active:
  - Counter is unaffected.
  - o_miss[i] is registered and equals 1 in the next cycle.
  - A trigger in the last active cycle is also missed; the level falls on schedule.
- Trigger while idle in the same cycle o_done[i] is high: accepted normally. The level rises again after exactly one low cycle.
- Held input: signal[i] held high counts as a trigger every cycle.
  - RETRIG=1: the level is held and ends len cycles after the last high cycle.
  - RETRIG=0: a new stretch starts one cycle after each expiry, and o_miss pulses on every active-cycle trigger.
- Channel independence: channels are fully independent; simultaneous triggers on any subset all load the same len.
- o_busy: combinational OR of o_level.
- Latency: trigger to level rise is 1 cycle. Level fall to done is 0 cycles (same cycle).

Test Plan:
- Basic: RETRIG=1, len=3, pulse signal[0] at edge 10 -> o_level[0] high cycles 11-13, o_done[0] high cycle 14 only, o_busy mirrors o_level[0].
- Retrigger: RETRIG=1, len=4, pulses at edges 10 and 12 -> o_level[0] high cycles 11-16 continuously, single o_done at 17. Repeat with the second pulse at edge 14 (last active cycle) -> high 11-18, done at 19.
- Non-retrigger: RETRIG=0, len=4, pulses at edges 10 and 12 -> o_level[0] high 11-14, o_miss[0] at 13, o_done[0] at 15. Pulse at edge 15 -> level 16-19.
- Zero length: len=0, pulse signal[3] -> no o_level, o_done or o_miss activity for 20 cycles.
- Multi-channel and full width: CNTW=8, len=255, signal=8'hFF at edge 5 -> all o_level high 6-260, o_done=8'hFF at 261. Counter does not wrap.
- Reset mid-stretch: len=10, trigger at edge 10, rst_n low asynchronously at 14.5 -> o_level drops immediately, no o_done. After release, a new trigger behaves as the Basic case.

Source files
------------

// File: rtl/pulse_stretch.sv
// Multi-channel pulse-to-level stretcher: each accepted trigger drives a level
// for len cycles, then a one-cycle done pulse; optional retrigger/extension.
module pulse_stretch #(
   parameter int WIDTH  = 8,
   parameter int CNTW   = 8,
   parameter int RETRIG = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] signal,
   input  logic [CNTW-1:0]  len,
   output logic [WIDTH-1:0] o_level,
   output logic [WIDTH-1:0] o_done,
   output logic [WIDTH-1:0] o_miss,
   output logic             o_busy
);

   localparam logic [CNTW-1:0] ONE = CNTW'(1);

   logic [CNTW-1:0]  r_cnt [WIDTH];
   logic [WIDTH-1:0] r_done;
   logic [WIDTH-1:0] r_miss;

   logic [WIDTH-1:0] w_active;
   logic [WIDTH-1:0] w_accept;
   logic [WIDTH-1:0] w_drop;
   logic             w_len_ok;

   // NOTE: every output of always_comb gets a default before any condition, so no latch can be inferred.
   always_comb begin
      w_len_ok = (len != '0);
      w_active = '0;
      w_accept = '0;
      w_drop   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_active[i] = (r_cnt[i] != '0);
         w_accept[i] = signal[i] && w_len_ok && (!w_active[i] || (RETRIG != 0));
         w_drop[i]   = signal[i] && w_len_ok && w_active[i] && (RETRIG == 0);
      end
   end

   // NOTE: the counter array is reset (not just the flags) because o_level is
   // decoded straight from it; sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
         r_done <= '0;
         r_miss <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_accept[i])      r_cnt[i] <= len;
            else if (w_active[i]) r_cnt[i] <= r_cnt[i] - ONE;
            // A reload in the final active cycle suppresses the done pulse.
            r_done[i] <= (r_cnt[i] == ONE) && !w_accept[i];
         end
         r_miss <= w_drop;
      end
   end

   assign o_level = w_active;
   assign o_done  = r_done;
   assign o_miss  = r_miss;
   assign o_busy  = |w_active;

endmodule
